// File: rtl/uart_rx_param_if.sv
// Consumer-side bundle of the UART receiver: held word, per-word flags and the valid/ready handshake.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 brk;
    logic                 overrun;
    logic                 ovr_clr;

    modport master (
        output data, valid, parity_err, frame_err, brk, overrun,
        input  ready, ovr_clr
    );

    modport slave (
        input  data, valid, parity_err, frame_err, brk, overrun,
        output ready, ovr_clr
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: rx synchroniser, oversampling bit timer with a 3-sample vote,
// configurable deframer and a one-entry valid/ready holding register with error flags.
module uart_rx_param #(
    parameter int CLK_DIV    = 4,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_i,
    uart_rx_param_if.master rx_if
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_PRE    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  OS_DEC    = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_BRK_WAIT = 3'd5
    } state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic exp_parity(input logic [DATA_BITS-1:0] w);
        return (PARITY == 1) ? ~(^w) : (^w);
    endfunction

    state_e               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic                 armed_q, armed_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 samp_pre_q, samp_pre_d;
    logic                 samp_mid_q, samp_mid_d;
    logic                 par_bit_q, par_bit_d;
    logic                 p_err_q, p_err_d;
    logic                 f_err_q, f_err_d;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic                 brk_q, brk_d;
    logic                 ovr_q, ovr_d;

    logic rx_s, tick_s, dec_s, vote_s, brk_now_s;
    logic done_s, done_fe_s, done_brk_s, load_s;

    assign rx_s   = sync2_q;
    assign tick_s = (div_cnt_q == DIV_LAST);
    assign dec_s  = tick_s && (os_cnt_q == OS_DEC);
    assign vote_s = maj3(samp_pre_q, samp_mid_q, rx_s);
    // A break is recognised on the first stop bit only, with every earlier bit low.
    assign brk_now_s = (bit_cnt_q == 4'd0) && !vote_s &&
                       (shift_q == {DATA_BITS{1'b0}}) && ((PARITY == 0) || !par_bit_q);

    // Bit timer, majority sampler and deframing FSM next-state.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        div_cnt_d  = div_cnt_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        samp_pre_d = samp_pre_q;
        samp_mid_d = samp_mid_q;
        par_bit_d  = par_bit_q;
        p_err_d    = p_err_q;
        f_err_d    = f_err_q;
        done_s     = 1'b0;
        done_fe_s  = f_err_q;
        done_brk_s = 1'b0;

        if ((state_q == S_IDLE) || (state_q == S_BRK_WAIT)) begin
            div_cnt_d = {DIV_W{1'b0}};
            os_cnt_d  = {OS_W{1'b0}};
        end else if (tick_s) begin
            div_cnt_d = {DIV_W{1'b0}};
            os_cnt_d  = (os_cnt_q == OS_LAST) ? {OS_W{1'b0}} : os_cnt_q + OS_W'(1);
            if (os_cnt_q == OS_PRE) begin
                samp_pre_d = rx_s;
            end else if (os_cnt_q == OS_MID) begin
                samp_mid_d = rx_s;
            end else begin
                samp_pre_d = samp_pre_q;
            end
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                // Only a fall seen after the line was high in IDLE counts as a start edge.
                if (armed_q && !rx_s) begin
                    state_d   = S_START;
                    armed_d   = 1'b0;
                    bit_cnt_d = 4'd0;
                    par_bit_d = 1'b0;
                    p_err_d   = 1'b0;
                    f_err_d   = 1'b0;
                end else begin
                    armed_d = armed_q | rx_s;
                end
            end
            S_START: begin
                if (dec_s) begin
                    state_d = vote_s ? S_IDLE : S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (dec_s) begin
                    shift_d = {vote_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = 4'd0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (dec_s) begin
                    par_bit_d = vote_s;
                    p_err_d   = (vote_s != exp_parity(shift_q));
                    bit_cnt_d = 4'd0;
                    state_d   = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (dec_s) begin
                    if (brk_now_s) begin
                        done_s     = 1'b1;
                        done_fe_s  = 1'b1;
                        done_brk_s = 1'b1;
                        state_d    = S_BRK_WAIT;
                    end else if (bit_cnt_q == STOP_LAST) begin
                        done_s    = 1'b1;
                        done_fe_s = f_err_q | ~vote_s;
                        state_d   = S_IDLE;
                    end else begin
                        f_err_d   = f_err_q | ~vote_s;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_BRK_WAIT: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BRK_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign load_s = done_s && (!valid_q || rx_if.ready);

    // Holding register, handshake and sticky overrun next-state.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        brk_d   = brk_q;
        ovr_d   = ovr_q;

        if (load_s) begin
            data_d  = shift_q;
            pe_d    = p_err_q;
            fe_d    = done_fe_s;
            brk_d   = done_brk_s;
            valid_d = 1'b1;
        end else if (valid_q && rx_if.ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // A new drop has priority over a clear in the same cycle.
        if (done_s && !load_s) begin
            ovr_d = 1'b1;
        end else if (rx_if.ovr_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // All state; async reset abandons any frame in flight and idles the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            div_cnt_q  <= {DIV_W{1'b0}};
            os_cnt_q   <= {OS_W{1'b0}};
            bit_cnt_q  <= 4'd0;
            shift_q    <= {DATA_BITS{1'b0}};
            samp_pre_q <= 1'b1;
            samp_mid_q <= 1'b1;
            par_bit_q  <= 1'b0;
            p_err_q    <= 1'b0;
            f_err_q    <= 1'b0;
            data_q     <= {DATA_BITS{1'b0}};
            valid_q    <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q    <= rx_i;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            armed_q    <= armed_d;
            div_cnt_q  <= div_cnt_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            samp_pre_q <= samp_pre_d;
            samp_mid_q <= samp_mid_d;
            par_bit_q  <= par_bit_d;
            p_err_q    <= p_err_d;
            f_err_q    <= f_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_if.data       = data_q;
    assign rx_if.valid      = valid_q;
    assign rx_if.parity_err = pe_q;
    assign rx_if.frame_err  = fe_q;
    assign rx_if.brk        = brk_q;
    assign rx_if.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench: an 8N1 receiver and a 7E2 receiver fed serial frames and checked
// against a frame-level model of the expected word and flags.
module tb_uart_rx_param;
    localparam int BIT_CLKS = 64;
    localparam int LAT_NOM  = 2 + (9 * 16 + 16 / 2 + 1) * 4 + 1;

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       brk;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rx_a;
    logic rx_b;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pops_a = 0;
    int   pops_b = 0;
    int   last_pop_cyc_a = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    uart_rx_param_if #(.DATA_BITS(8)) ifa ();
    uart_rx_param_if #(.DATA_BITS(7)) ifb ();

    uart_rx_param #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rx_i(rx_a), .rx_if(ifa)
    );
    uart_rx_param #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .rx_i(rx_b), .rx_if(ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected word and flags for one frame, from the bits put on the line.
    function automatic exp_t model(input int nb, input int pm, input int ns, input logic [8:0] d,
                                   input logic pbit, input logic [1:0] stops);
        exp_t e;
        int   ones;
        ones = 0;
        for (int i = 0; i < nb; i++) ones += int'(d[i]);
        e.data = d;
        e.pe   = (pm != 0) && (pbit != (((ones % 2) == 1) ^ (pm == 1)));
        e.brk  = (d == 9'd0) && ((pm == 0) || (pbit == 1'b0)) && (stops[0] == 1'b0);
        e.fe   = 1'b0;
        for (int i = 0; i < ns; i++) if (stops[i] == 1'b0) e.fe = 1'b1;
        return e;
    endfunction

    task automatic drive_bit(input int which, input logic lvl);
        if (which == 0) rx_a = lvl;
        else rx_b = lvl;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [8:0] d, input logic flip,
                              input logic [1:0] stops, input bit push);
        int   nb, pm, ns, ones;
        logic pbit;
        nb   = (which == 0) ? 8 : 7;
        pm   = (which == 0) ? 0 : 2;
        ns   = (which == 0) ? 1 : 2;
        ones = 0;
        for (int i = 0; i < nb; i++) ones += int'(d[i]);
        pbit = ((((ones % 2) == 1) ^ (pm == 1)) ? 1'b1 : 1'b0) ^ flip;
        if (push) begin
            if (which == 0) q_a.push_back(model(nb, pm, ns, d, pbit, stops));
            else q_b.push_back(model(nb, pm, ns, d, pbit, stops));
        end
        drive_bit(which, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(which, d[i]);
        if (pm != 0) drive_bit(which, pbit);
        for (int i = 0; i < ns; i++) drive_bit(which, stops[i]);
        drive_bit(which, 1'b1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_a_valid"}, ifa.valid, 0);
        chk({tag, "_a_data"}, ifa.data, 0);
        chk({tag, "_a_flags"}, {ifa.parity_err, ifa.frame_err, ifa.brk, ifa.overrun}, 0);
        chk({tag, "_b_valid"}, ifb.valid, 0);
        chk({tag, "_b_data"}, ifb.data, 0);
        chk({tag, "_b_flags"}, {ifb.parity_err, ifb.frame_err, ifb.brk, ifb.overrun}, 0);
    endtask

    // Pops the scoreboard whenever a receiver hands over a word.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && ifa.valid && ifa.ready) begin
                pops_a++;
                last_pop_cyc_a = cyc;
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected: got word 0x%0h, expected none", ifa.data);
                end else begin
                    e = q_a.pop_front();
                    chk("a_data", ifa.data, e.data);
                    chk("a_flags pe/fe/brk", {ifa.parity_err, ifa.frame_err, ifa.brk}, {e.pe, e.fe, e.brk});
                end
            end
            if (!rst && ifb.valid && ifb.ready) begin
                pops_b++;
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got word 0x%0h, expected none", ifb.data);
                end else begin
                    e = q_b.pop_front();
                    chk("b_data", ifb.data, e.data);
                    chk("b_flags pe/fe/brk", {ifb.parity_err, ifb.frame_err, ifb.brk}, {e.pe, e.fe, e.brk});
                end
            end
        end
    endtask

    task automatic stimulus();
        int c0, v, seen, lat;
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);

        // 8N1 0xA5 and rx-fall to valid latency.
        v  = pops_a;
        c0 = cyc;
        send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b1);
        chk("a5_words", pops_a - v, 1);
        lat = last_pop_cyc_a - c0;
        chk("a5_latency_in_window", ((lat >= LAT_NOM - 4) && (lat <= LAT_NOM + 4)) ? 1 : 0, 1);

        // Short low glitch is a false start, then a clean frame.
        v = pops_a;
        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        rx_a = 1'b1;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (ifa.valid) seen++;
        end
        chk("glitch_valid_cycles", seen, 0);
        send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b1);
        chk("glitch_then_3c_words", pops_a - v, 1);

        // Overrun with the consumer stalled.
        ifa.ready = 1'b0;
        send_frame(0, 9'h011, 1'b0, 2'b11, 1'b1);
        send_frame(0, 9'h022, 1'b0, 2'b11, 1'b0);
        chk("ovr_set", ifa.overrun, 1);
        chk("ovr_valid_held", ifa.valid, 1);
        chk("ovr_data_held", ifa.data, 8'h11);
        ifa.ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("ovr_consumed_valid", ifa.valid, 0);
        chk("ovr_sticky", ifa.overrun, 1);
        ifa.ovr_clr = 1'b1;
        @(negedge clk);
        ifa.ovr_clr = 1'b0;
        chk("ovr_cleared", ifa.overrun, 0);

        // Reset in the middle of a frame.
        v = pops_a;
        fork
            send_frame(0, 9'h099, 1'b0, 2'b11, 1'b0);
            begin
                repeat (4 * BIT_CLKS) @(negedge clk);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                check_outputs_zero("midrst");
            end
        join
        rst = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        send_frame(0, 9'h042, 1'b0, 2'b11, 1'b1);
        chk("rst_then_42_words", pops_a - v, 1);

        // 7E2: good and bad parity, late stop error, then a long break.
        v = pops_b;
        send_frame(1, 9'h055, 1'b0, 2'b11, 1'b1);
        send_frame(1, 9'h055, 1'b1, 2'b11, 1'b1);
        send_frame(1, 9'h00F, 1'b0, 2'b01, 1'b1);
        chk("b_fixed_words", pops_b - v, 3);
        v = pops_b;
        q_b.push_back(model(7, 2, 2, 9'h000, 1'b0, 2'b00));
        rx_b = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        rx_b = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        chk("brk_words", pops_b - v, 1);

        // Randomised traffic on both receivers at once.
        fork
            for (int i = 0; i < 16; i++)
                send_frame(0, 9'($urandom_range(0, 255)), 1'b0,
                           {1'b1, ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1}, 1'b1);
            for (int j = 0; j < 16; j++)
                send_frame(1, 9'($urandom_range(0, 127)), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                           {($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1, ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1},
                           1'b1);
        join
        repeat (2 * BIT_CLKS) @(negedge clk);
        chk("a_words_outstanding", q_a.size(), 0);
        chk("b_words_outstanding", q_b.size(), 0);
    endtask

    initial begin
        rst         = 1'b1;
        rx_a        = 1'b1;
        rx_b        = 1'b1;
        ifa.ready   = 1'b1;
        ifa.ovr_clr = 1'b0;
        ifb.ready   = 1'b1;
        ifb.ovr_clr = 1'b0;
        fork
            monitor();
            stimulus();
            begin
                repeat (90000) @(posedge clk);
                checks++;
                errors++;
                $display("FAIL watchdog: got no end of stimulus, expected it within 90000 cycles");
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receive engine, the successor to the fixed 8N1 receiver. It synchronises the rx line, generates its own oversampling tick from clk, and deframes a configurable word (data width, parity, stop bits). The word goes out through a one-entry valid/ready holding register with per-word error flags. It sits between the pad-side rx pin and any byte consumer (FIFO, bus bridge) in the same clk domain.

Parameters:
CLK_DIV, 4, clk cycles per oversample tick (>=1)
OVERSAMPLE, 16, ticks per bit period (even, >=8)
DATA_BITS, 8, data bits per frame (5..9)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked (1 or 2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rx  in  1  serial line, idle high, asynchronous to clk
data  out  DATA_BITS  received word, LSB = first bit on the line
valid  out  1  data and flags are held and stable
ready  in  1  consumer accepts the word when valid && ready
parity_err  out  1  parity mismatch for the held word (0 when PARITY = 0)
frame_err  out  1  a stop bit was sampled low for the held word
brk  out  1  break: all data bits 0, parity 0 and stop 0
overrun  out  1  sticky: a frame was dropped because the holding register was full
ovr_clr  in  1  synchronous clear of overrun

Behaviour:
- Reset (async): state IDLE, sync flops = 1, all counters 0; data, valid, parity_err, frame_err, brk, overrun = 0. Reset mid-frame aborts the frame with no output.
- Sync: 2-flop synchroniser on rx; rx_s is the second stage. All logic uses rx_s only.
- Tick: div_cnt counts 0..CLK_DIV-1 and wraps. tick = (div_cnt == CLK_DIV-1). While IDLE, div_cnt is held at 0.
- os_cnt counts ticks 0..OVERSAMPLE-1 within a bit. Sample point is os_cnt == OVERSAMPLE/2. Bit value = majority of rx_s at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The decision is taken at tick OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE: when rx_s is 0 (falling edge; the line must have been 1 for at least one clk since IDLE entry), go to START with os_cnt = 0.
- START: at the decision tick, a voted 0 proceeds. A voted 1 is a false start: return to IDLE, no output, no flag.
- After the start decision, all counters re-align so each subsequent decision occurs OVERSAMPLE ticks after the previous one.
- DATA: shift voted bits in LSB-first. bit_cnt runs 0..DATA_BITS-1. After the last bit, go to PARITY if PARITY != 0, else to STOP.
- PARITY: expected value is XOR of data bits (even), inverted for odd. Mismatch sets p_err_n.
- STOP: checks STOP_BITS stop bits. Any stop bit voted 0 sets f_err_n. If the first stop bit is 0 with data and parity all 0, the frame is a break: set brk_n and go to BRK_WAIT.
- Frame completion: at the last stop-bit decision, the frame completes and the FSM goes to IDLE immediately. There is no wait for the end of the stop bit, so back-to-back frames are accepted.
- BRK_WAIT: stay until rx_s == 1, then go to IDLE. No further output is produced during the break.
- Output load: on frame completion, if !valid or (valid && ready) in the same cycle, the next clk edge loads data, parity_err, frame_err and brk, and sets valid = 1.
- Overrun: otherwise the frame is dropped and overrun is set to 1. The held word and its flags are unchanged.
- Handshake: valid && ready with no simultaneous load -> valid = 0 next edge. data and flags hold their last values and are don't-care while valid = 0. valid never drops without ready.
- ovr_clr: clears overrun next edge. If ovr_clr coincides with a new overrun event, set wins.
- Latency: valid rises on the clk edge following the final stop-bit decision tick.
- Latency, default parameters, 8N1: rx fall -> valid rise is 2 sync cycles + (9*OVERSAMPLE + OVERSAMPLE/2+1)*CLK_DIV + 1 cycle, +-CLK_DIV.
- Widths: os_cnt is clog2(OVERSAMPLE) bits; div_cnt is clog2(CLK_DIV) bits (min 1); bit_cnt is 4 bits.

Test Plan:
- Default params, send 8N1 0xA5 at 64 clk/bit, ready=1 -> one valid pulse with data=0xA5, parity_err=0, frame_err=0, brk=0; latency within +-4 clk of formula.
- Glitch: 16-clk low pulse on idle rx -> false start; valid stays 0, FSM back in IDLE, then 0x3C received correctly.
- PARITY=2, DATA_BITS=7, send 0x55 with correct parity, then 0x55 with flipped parity -> parity_err = 0 then 1, data=0x55 both times.
- STOP_BITS=2, second stop bit driven low on 0x0F -> data=0x0F, frame_err=1. Then hold rx=0 for 20 bit times -> one word data=0x00, brk=1, frame_err=1; no further words until rx returns high.
- ready=0, send 0x11 then 0x22 -> data=0x11 held, overrun=1. Raise ready -> 0x11 consumed, valid=0. Pulse ovr_clr -> overrun=0.
- Assert rst mid-data of 0x99, release, send 0x42 -> no word for 0x99, data=0x42 valid; all outputs 0 during reset.
